multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states and drives every datapath enable and mux select. It is the producer of the 2-bit `aluop` code that the ALU control decoder consumes: 00 = add, 01 = subtract, 10 = use funct. A `mem_ready` handshake stalls the FSM on slow instruction and data memory.

---
 rtl/multicycle_control.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
//
// Sequences each instruction through fetch, decode, execute, memory and
// writeback states and drives every datapath enable and mux select. The
// memory handshake (mem_ready_i) stretches FETCH, MEMRD and MEMWR.
//
// Ports:
//   clk_i          clock, all state changes on the rising edge
//   rst_ni         synchronous active-low reset
//   opcode_i       IR[31:26], sampled only in DECODE
//   mem_ready_i    memory completes the current read/write this cycle
//   pcwrite_o      unconditional PC load
//   pcwritecond_o  PC load gated externally by ALU zero
//   iord_o         memory address select (0 = PC, 1 = ALUOut)
//   memread_o      memory read request
//   memwrite_o     memory write request
//   irwrite_o      instruction register load
//   memtoreg_o     register write data select (0 = ALUOut, 1 = MDR)
//   regdst_o       destination register select (0 = rt, 1 = rd)
//   regwrite_o     register file write enable
//   alusrca_o      ALU A select (0 = PC, 1 = A)
//   alusrcb_o      ALU B select (00 = B, 01 = 4, 10 = imm, 11 = imm << 2)
//   aluop_o        ALU control code (00 = add, 01 = sub, 10 = funct)
//   pcsource_o     PC source (00 = ALU, 01 = ALUOut, 10 = jump target)
//   state_o        current state, for debug
//   illegal_o      one-cycle pulse when DECODE sees an unsupported opcode
module multicycle_control (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pcwrite_o,
    output logic       pcwritecond_o,
    output logic       iord_o,
    output logic       memread_o,
    output logic       memwrite_o,
    output logic       irwrite_o,
    output logic       memtoreg_o,
    output logic       regdst_o,
    output logic       regwrite_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] aluop_o,
    output logic [1:0] pcsource_o,
    output logic [3:0] state_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    state_e state_q, state_d;
    state_e dec_state;
    logic   is_lw_q, is_lw_d;

    // Raw strobes before reset gating.
    logic pcwrite_s, pcwritecond_s, memread_s, memwrite_s;
    logic irwrite_s, regwrite_s, illegal_s;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StFetch;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_lw_q <= is_lw_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        is_lw_d = is_lw_q;
        case (state_q)
            StFetch: begin
                if (mem_ready_i) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // Remember lw vs sw so MEMADR does not depend on a live opcode.
                is_lw_d = (opcode_i == OpLw);
                case (opcode_i)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = is_lw_q ? StMemRd : StMemWr;
            StMemRd: begin
                if (mem_ready_i) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: state_d = StFetch;
            StMemWr: begin
                if (mem_ready_i) begin
                    state_d = StFetch;
                end
            end
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            // Encodings 10-15 recover to FETCH.
            default:  state_d = StFetch;
        endcase
    end

    // While in reset the selects show the FETCH decode regardless of state_q.
    assign dec_state = rst_ni ? state_q : StFetch;

    // Moore output decode, with mem_ready qualifying the FETCH strobes.
    always_comb begin
        pcwrite_s     = 1'b0;
        pcwritecond_s = 1'b0;
        memread_s     = 1'b0;
        memwrite_s    = 1'b0;
        irwrite_s     = 1'b0;
        regwrite_s    = 1'b0;
        illegal_s     = 1'b0;
        iord_o        = 1'b0;
        memtoreg_o    = 1'b0;
        regdst_o      = 1'b0;
        alusrca_o     = 1'b0;
        alusrcb_o     = 2'b00;
        aluop_o       = 2'b00;
        pcsource_o    = 2'b00;
        case (dec_state)
            StFetch: begin
                memread_s = 1'b1;
                alusrcb_o = 2'b01;
                irwrite_s = mem_ready_i;
                pcwrite_s = mem_ready_i;
            end
            StDecode: begin
                alusrcb_o = 2'b11;
                case (opcode_i)
                    OpRtype, OpLw, OpSw, OpBeq, OpJ: illegal_s = 1'b0;
                    default:                         illegal_s = 1'b1;
                endcase
            end
            StMemAdr: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
            end
            StMemRd: begin
                memread_s = 1'b1;
                iord_o    = 1'b1;
            end
            StMemWb: begin
                regwrite_s = 1'b1;
                memtoreg_o = 1'b1;
            end
            StMemWr: begin
                memwrite_s = 1'b1;
                iord_o     = 1'b1;
            end
            StExec: begin
                alusrca_o = 1'b1;
                aluop_o   = 2'b10;
            end
            StAluWb: begin
                regwrite_s = 1'b1;
                regdst_o   = 1'b1;
            end
            StBranch: begin
                alusrca_o     = 1'b1;
                aluop_o       = 2'b01;
                pcwritecond_s = 1'b1;
                pcsource_o    = 2'b01;
            end
            StJump: begin
                pcwrite_s  = 1'b1;
                pcsource_o = 2'b10;
            end
            default: ;
        endcase
    end

    // No strobe may fire while reset is held low.
    assign pcwrite_o     = pcwrite_s & rst_ni;
    assign pcwritecond_o = pcwritecond_s & rst_ni;
    assign memread_o     = memread_s & rst_ni;
    assign memwrite_o    = memwrite_s & rst_ni;
    assign irwrite_o     = irwrite_s & rst_ni;
    assign regwrite_o    = regwrite_s & rst_ni;
    assign illegal_o     = illegal_s & rst_ni;
    assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A behavioural model expands
// each instruction into its expected sequence of states (including memory
// stalls) and predicts every control output per cycle from the state table.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       illegal;
    } ctl_t;

    localparam logic [5:0] OpR   = 6'b000000;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpSw  = 6'b101011;
    localparam logic [5:0] OpBeq = 6'b000100;
    localparam logic [5:0] OpJ   = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, illegal;
    logic [1:0] alusrcb, aluop, pcsource;
    logic [3:0] state;
    ctl_t       obs;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .opcode_i      (opcode),
        .mem_ready_i   (mem_ready),
        .pcwrite_o     (pcwrite),
        .pcwritecond_o (pcwritecond),
        .iord_o        (iord),
        .memread_o     (memread),
        .memwrite_o    (memwrite),
        .irwrite_o     (irwrite),
        .memtoreg_o    (memtoreg),
        .regdst_o      (regdst),
        .regwrite_o    (regwrite),
        .alusrca_o     (alusrca),
        .alusrcb_o     (alusrcb),
        .aluop_o       (aluop),
        .pcsource_o    (pcsource),
        .state_o       (state),
        .illegal_o     (illegal)
    );

    always #5 clk = ~clk;

    assign obs = '{pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                   regdst, regwrite, alusrca, alusrcb, aluop, pcsource, illegal};

    function automatic logic legal_op(input logic [5:0] op);
        return op == OpR || op == OpLw || op == OpSw || op == OpBeq || op == OpJ;
    endfunction

    // Expected control word for a state, straight from the state table.
    function automatic ctl_t model_out(input int st, input logic mr, input logic [5:0] op,
                                       input logic rst);
        ctl_t c = '0;
        if (!rst) begin
            c.alusrcb = 2'b01;
            return c;
        end
        case (st)
            0: begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
            1: begin c.alusrcb = 2'b11; c.illegal = !legal_op(op); end
            2: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            3: begin c.memread = 1; c.iord = 1; end
            4: begin c.regwrite = 1; c.memtoreg = 1; end
            5: begin c.memwrite = 1; c.iord = 1; end
            6: begin c.alusrca = 1; c.aluop = 2'b10; end
            7: begin c.regwrite = 1; c.regdst = 1; end
            8: begin c.alusrca = 1; c.aluop = 2'b01; c.pcwritecond = 1; c.pcsource = 2'b01; end
            9: begin c.pcwrite = 1; c.pcsource = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    // One clock cycle: drive inputs, check at the falling edge, advance.
    task automatic step(input logic [5:0] op, input logic mr, input int st, input string tag);
        ctl_t exp;
        opcode    = op;
        mem_ready = mr;
        exp       = model_out(st, mr, op, rst_n);
        @(negedge clk);
        checks++;
        assert (state === st[3:0]) else begin
            errors++;
            $error("FAIL %s state got %0d want %0d", tag, state, st);
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s ctl in state %0d got %h want %h", tag, st, obs, exp);
        end
        checks++;
        assert (aluop !== 2'b11) else begin
            errors++;
            $error("FAIL %s aluop got %b want not 11", tag, aluop);
        end
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its state walk; opcode is random outside DECODE.
    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                             input string tag);
        int   sq[$];
        logic mq[$];
        for (int i = 0; i < fstall; i++) begin sq.push_back(0); mq.push_back(1'b0); end
        sq.push_back(0); mq.push_back(1'b1);
        sq.push_back(1); mq.push_back(1'($urandom));
        if (op == OpLw || op == OpSw) begin
            sq.push_back(2); mq.push_back(1'($urandom));
            for (int i = 0; i < mstall; i++) begin
                sq.push_back(op == OpLw ? 3 : 5); mq.push_back(1'b0);
            end
            sq.push_back(op == OpLw ? 3 : 5); mq.push_back(1'b1);
            if (op == OpLw) begin sq.push_back(4); mq.push_back(1'($urandom)); end
        end else if (op == OpR) begin
            sq.push_back(6); mq.push_back(1'($urandom));
            sq.push_back(7); mq.push_back(1'($urandom));
        end else if (op == OpBeq) begin
            sq.push_back(8); mq.push_back(1'($urandom));
        end else if (op == OpJ) begin
            sq.push_back(9); mq.push_back(1'($urandom));
        end
        foreach (sq[i]) begin
            step(sq[i] == 1 ? op : 6'($urandom), mq[i], sq[i], tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] op;
        rst_n     = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b1;
        #1;
        // Before any edge the outputs already show the gated FETCH decode.
        checks++;
        assert (obs === model_out(0, 1'b1, 6'd0, 1'b0)) else begin
            errors++;
            $error("FAIL reset_ctl got %h want %h", obs, model_out(0, 1'b1, 6'd0, 1'b0));
        end
        @(posedge clk); #1;
        step(OpR, 1'b1, 0, "reset_hold");
        rst_n = 1'b1;

        // Directed test plan.
        run_instr(OpR, 0, 0, "rtype");
        run_instr(OpLw, 2, 3, "lw_stall");
        run_instr(OpSw, 0, 0, "sw");
        run_instr(OpBeq, 0, 0, "beq");
        run_instr(OpJ, 0, 0, "jump");
        run_instr(6'b111111, 0, 0, "illegal");

        // Reset dropped in MEMWR while stalled.
        step(OpSw, 1'b1, 0, "rst_fetch");
        step(OpSw, 1'b1, 1, "rst_decode");
        step(OpLw, 1'b1, 2, "rst_memadr");
        step(OpLw, 1'b0, 5, "rst_memwr");
        rst_n = 1'b0;
        step(OpLw, 1'b0, 5, "rst_abort");
        step(OpR, 1'b1, 0, "rst_low1");
        step(OpJ, 1'b1, 0, "rst_low2");
        rst_n = 1'b1;
        run_instr(OpR, 1, 0, "post_reset");

        // Randomized instruction mix with random stalls.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: op = OpR;
                1: op = OpLw;
                2: op = OpSw;
                3: op = OpBeq;
                4: op = OpJ;
                default: begin
                    op = 6'($urandom);
                    while (legal_op(op)) op = 6'($urandom);
                end
            endcase
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
        step(OpR, 1'b0, 0, "final_fetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
